// File: rtl/key_scan_pkg.sv
// Shared definitions for the 74HC165 key scanner: scan FSM encoding, default geometry
// and the debounce counter helper.
package key_scan_pkg;

    localparam int KS_WIDTH_DEF      = 16;
    localparam int KS_DIV_DEF        = 256;
    localparam int KS_DEB_FRAMES_DEF = 3;
    localparam int KS_DEB_CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_SHIFT_HI = 3'd4,
        ST_DONE     = 3'd5
    } ks_state_e;

    // Saturating increment so a stable input keeps the match count pinned at the limit.
    function automatic logic [KS_DEB_CNT_W-1:0] deb_sat_inc(
        input logic [KS_DEB_CNT_W-1:0] cnt,
        input logic [KS_DEB_CNT_W-1:0] lim
    );
        logic [KS_DEB_CNT_W-1:0] res;
        if (cnt >= lim) begin
            res = lim;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/key_scan_hc165_if.sv
// Control-side bus of the key scanner: scan enable in, accepted key vector and strobes out.
interface key_scan_hc165_if import key_scan_pkg::*; #(
    parameter int WIDTH = KS_WIDTH_DEF
) ();

    logic             scan_en;
    logic [WIDTH-1:0] keys;
    logic             valid;
    logic             changed;

    modport master (output scan_en, input keys, input valid, input changed);
    modport slave  (input scan_en, output keys, output valid, output changed);

endinterface

// File: rtl/tick_div.sv
// Prescaler producing a one-cycle tick every DIV sys_clk cycles (tick while count is DIV-1).
module tick_div #(
    parameter int DIV = 256
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          tick_r;

    // Next count wraps at LAST.
    always_comb begin
        cnt_s = cnt_r;
        if (cnt_r == LAST) begin
            cnt_s = CW'(0);
        end else begin
            cnt_s = cnt_r + CW'(1);
        end
    end

    // Counter plus a registered tick that is high exactly while the count sits at LAST.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_r  <= CW'(0);
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            tick_r <= (cnt_s == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/key_scan_hc165.sv
// 74HC165 chain reader: load, shift WIDTH bits MSB-first, deliver keys with valid/changed.
// Optional debounce enabled by defining KEY_SCAN_DEBOUNCE_EN.
module key_scan_hc165 import key_scan_pkg::*; #(
    parameter int WIDTH      = KS_WIDTH_DEF,
    parameter int DIV        = KS_DIV_DEF,
    parameter int DEB_FRAMES = KS_DEB_FRAMES_DEF
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    key_scan_hc165_if.slave        bus,
    input  logic                   dat,
    output logic                   clk,
    output logic                   ld
);

    localparam int            BW       = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
        $error("key_scan_hc165: WIDTH must be a multiple of 8 in 8..64");
    end
    if (DIV < 2 || DIV > 65535) begin : g_bad_div
        $error("key_scan_hc165: DIV must be in 2..65535");
    end
    if (DEB_FRAMES < 2 || DEB_FRAMES > 15) begin : g_bad_deb
        $error("key_scan_hc165: DEB_FRAMES must be in 2..15");
    end

    ks_state_e        state_r, state_s;
    logic [BW-1:0]    bit_cnt_r, bit_cnt_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic             clk_r, clk_s;
    logic             ld_r, ld_s;
    logic             frame_done_s;
    logic             accept_s;
    logic [WIDTH-1:0] keys_r;
    logic             valid_r;
    logic             changed_r;
    logic             tick_s;

    tick_div #(.DIV(DIV)) u_tick_div (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tick      (tick_s)
    );

    // Scan FSM next state; pin levels are computed for the state being entered.
    always_comb begin
        state_s      = state_r;
        bit_cnt_s    = bit_cnt_r;
        shreg_s      = shreg_r;
        clk_s        = clk_r;
        ld_s         = ld_r;
        frame_done_s = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    clk_s = 1'b0;
                    if (bus.scan_en) begin
                        state_s = ST_LOAD;
                        ld_s    = 1'b0;
                    end else begin
                        ld_s    = 1'b1;
                    end
                end
                ST_LOAD: begin
                    bit_cnt_s = BW'(0);
                    ld_s      = 1'b1;
                    state_s   = ST_SETTLE;
                end
                ST_SETTLE: begin
                    state_s = ST_SHIFT_LO;
                end
                ST_SHIFT_LO: begin
                    shreg_s = {shreg_r[WIDTH-2:0], dat};
                    clk_s   = 1'b1;
                    state_s = ST_SHIFT_HI;
                end
                ST_SHIFT_HI: begin
                    clk_s = 1'b0;
                    if (bit_cnt_r == BIT_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BW'(1);
                        state_s   = ST_SHIFT_LO;
                    end
                end
                ST_DONE: begin
                    frame_done_s = 1'b1;
                    if (bus.scan_en) begin
                        state_s = ST_LOAD;
                        ld_s    = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    clk_s   = 1'b0;
                    ld_s    = 1'b1;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Scan FSM state, bit counter, shift register and chain pins.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= BW'(0);
            shreg_r   <= {WIDTH{1'b1}};
            clk_r     <= 1'b0;
            ld_r      <= 1'b1;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            shreg_r   <= shreg_s;
            clk_r     <= clk_s;
            ld_r      <= ld_s;
        end
    end

`ifdef KEY_SCAN_DEBOUNCE_EN
    localparam logic [KS_DEB_CNT_W-1:0] DEB_LIM = KS_DEB_CNT_W'(DEB_FRAMES);

    logic [WIDTH-1:0]        cand_r, cand_s;
    logic [KS_DEB_CNT_W-1:0] match_r, match_s;

    // A differing frame restarts the candidate; acceptance once DEB_FRAMES frames agree.
    always_comb begin
        cand_s   = cand_r;
        match_s  = match_r;
        accept_s = 1'b0;
        if (frame_done_s) begin
            if (shreg_r == cand_r) begin
                match_s = deb_sat_inc(match_r, DEB_LIM);
            end else begin
                cand_s  = shreg_r;
                match_s = 4'd1;
            end
            accept_s = (match_s == DEB_LIM);
        end else begin
            accept_s = 1'b0;
        end
    end

    // Debounce candidate and consecutive-match count.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cand_r  <= {WIDTH{1'b1}};
            match_r <= 4'd0;
        end else begin
            cand_r  <= cand_s;
            match_r <= match_s;
        end
    end
`else
    assign accept_s = frame_done_s;
`endif

    // Delivered key vector and one-cycle strobes.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            keys_r    <= {WIDTH{1'b1}};
            valid_r   <= 1'b0;
            changed_r <= 1'b0;
        end else if (accept_s) begin
            keys_r    <= shreg_r;
            valid_r   <= 1'b1;
            changed_r <= (shreg_r != keys_r);
        end else begin
            valid_r   <= 1'b0;
            changed_r <= 1'b0;
        end
    end

    assign clk         = clk_r;
    assign ld          = ld_r;
    assign bus.keys    = keys_r;
    assign bus.valid   = valid_r;
    assign bus.changed = changed_r;

endmodule

// File: tb/tb_key_scan_hc165.sv
// Directed bench for key_scan_hc165 with behavioural 74HC165 chain models.
module tb_key_scan_hc165;

`ifdef KEY_SCAN_DEBOUNCE_EN
    localparam int FIRST_FRAMES = 3;
`else
    localparam int FIRST_FRAMES = 1;
`endif

    logic sys_clk = 1'b0;
    logic rst_a_n, rst_b_n;
    logic clk_a, ld_a, dat_a;
    logic clk_b, ld_b, dat_b;
    logic [15:0] pat_a, sr_a;
    logic [7:0]  pat_b, sr_b;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    key_scan_hc165_if #(.WIDTH(16)) bus_a ();
    key_scan_hc165_if #(.WIDTH(8))  bus_b ();

    key_scan_hc165 #(.WIDTH(16), .DIV(4), .DEB_FRAMES(3)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(rst_a_n), .bus(bus_a),
        .dat(dat_a), .clk(clk_a), .ld(ld_a)
    );

    key_scan_hc165 #(.WIDTH(8), .DIV(2), .DEB_FRAMES(3)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(rst_b_n), .bus(bus_b),
        .dat(dat_b), .clk(clk_b), .ld(ld_b)
    );

    always #5 sys_clk = ~sys_clk;

    // 74HC165 chains: PL low loads the pattern, CP rising shifts toward Q7, SER tied high.
    always @(posedge clk_a or negedge ld_a) begin
        if (!ld_a) sr_a <= pat_a;
        else       sr_a <= {sr_a[14:0], 1'b1};
    end
    assign dat_a = sr_a[15];

    always @(posedge clk_b or negedge ld_b) begin
        if (!ld_b) sr_b <= pat_b;
        else       sr_b <= {sr_b[6:0], 1'b1};
    end
    assign dat_b = sr_b[7];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance negedges until the selected DUT's valid is seen or n reaches budget.
    task automatic wait_valid(input bit sel_b, input int budget, inout int n, output bit ok);
        while (!(sel_b ? bus_b.valid : bus_a.valid) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        ok = sel_b ? bus_b.valid : bus_a.valid;
    endtask

    task automatic wait_ld_a(input logic lvl, input int budget, output bit ok);
        int n = 0;
        while (ld_a !== lvl && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        ok = (ld_a === lvl);
    endtask

    task automatic wait_rises_a(input int count, input int budget, output bit ok);
        int  n = 0;
        int  r = 0;
        logic prev = clk_a;
        while (r < count && n < budget) begin
            @(negedge sys_clk);
            n++;
            if (clk_a && !prev) r++;
            prev = clk_a;
        end
        ok = (r == count);
    endtask

    initial begin
        logic [15:0] seq_pat   [5];
        logic        seq_valid [5];
        logic [15:0] seq_keys  [5];
        logic        seq_chg   [5];
        int   n, ld_lo, pulses, clk_hi, got, bad, vcnt;
        bit   ok;
        logic prev_clk;

        seq_pat = '{16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0001};
`ifdef KEY_SCAN_DEBOUNCE_EN
        seq_valid = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        seq_keys  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001};
        seq_chg   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        seq_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        seq_keys  = '{16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0001};
        seq_chg   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`endif

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        bus_a.scan_en = 1'b1;
        bus_b.scan_en = 1'b1;
        pat_a = 16'hA5C3;
        pat_b = 8'h80;
        repeat (3) @(negedge sys_clk);

        // Reset state
        check("rst_clk", clk_a, 1'b0);
        check("rst_ld", ld_a, 1'b1);
        check("rst_keys", bus_a.keys, 16'hFFFF);
        check("rst_valid", bus_a.valid, 1'b0);
        check("rst_changed", bus_a.changed, 1'b0);

        // First frame: timing of ld/clk and delivery latency
        rst_a_n = 1'b1;
        wait_ld_a(1'b0, 20, ok);
        check("first_ld_low", ok, 1'b1);
        n = 0; ld_lo = 0; pulses = 0; clk_hi = 0; got = -1; prev_clk = 1'b0;
        while (n < 600) begin
            if (n < 140) begin
                if (!ld_a) ld_lo++;
                if (clk_a) clk_hi++;
                if (clk_a && !prev_clk) pulses++;
            end
            prev_clk = clk_a;
            if (bus_a.valid) begin
                got = n;
                break;
            end
            @(negedge sys_clk);
            n++;
        end
        check("ld_low_cycles", ld_lo, 4);
        check("clk_pulses", pulses, 16);
        check("clk_high_cycles", clk_hi, 64);
        check("first_valid_cycle", got, 140 * FIRST_FRAMES);
        check("frame1_keys", bus_a.keys, 16'hA5C3);
        check("frame1_changed", bus_a.changed, 1'b1);

        // Next frame, same pattern
        n = 0;
        @(negedge sys_clk);
        n++;
        check("valid_one_cycle", bus_a.valid, 1'b0);
        wait_valid(1'b0, 300, n, ok);
        check("frame2_valid", ok, 1'b1);
        check("frame_period", n, 140);
        check("frame2_keys", bus_a.keys, 16'hA5C3);
        check("frame2_changed", bus_a.changed, 1'b0);

        // Drop scan_en mid-frame: frame completes, then idle
        wait_rises_a(5, 100, ok);
        check("drop_rises", ok, 1'b1);
        bus_a.scan_en = 1'b0;
        n = 0;
        wait_valid(1'b0, 300, n, ok);
        check("drop_valid", ok, 1'b1);
        check("drop_keys", bus_a.keys, 16'hA5C3);
        bad = 0; vcnt = 0;
        for (int i = 0; i < 420; i++) begin
            @(negedge sys_clk);
            if (ld_a !== 1'b1 || clk_a !== 1'b0) bad++;
            if (bus_a.valid) vcnt++;
        end
        check("idle_pins", bad, 0);
        check("idle_no_valid", vcnt, 0);

        // Reset asserted at bit 9
        bus_a.scan_en = 1'b1;
        wait_ld_a(1'b0, 20, ok);
        check("restart_ld", ok, 1'b1);
        wait_rises_a(9, 100, ok);
        check("bit9_rises", ok, 1'b1);
        rst_a_n = 1'b0;
        @(negedge sys_clk);
        check("midrst_clk", clk_a, 1'b0);
        check("midrst_ld", ld_a, 1'b1);
        check("midrst_keys", bus_a.keys, 16'hFFFF);
        check("midrst_valid", bus_a.valid, 1'b0);
        vcnt = 0;
        repeat (3) begin
            @(negedge sys_clk);
            if (bus_a.valid) vcnt++;
        end
        check("midrst_no_valid", vcnt, 0);

        // Pattern sequence: 0001, 0000, 0001 x3
        pat_a = seq_pat[0];
        rst_a_n = 1'b1;
        wait_ld_a(1'b0, 20, ok);
        check("seq_start", ok, 1'b1);
        for (int i = 0; i < 5; i++) begin
            wait_ld_a(1'b1, 20, ok);
            if (i < 4) pat_a = seq_pat[i + 1];
            wait_ld_a(1'b0, 200, ok);
            check($sformatf("seq%0d_frame", i), ok, 1'b1);
            check($sformatf("seq%0d_valid", i), bus_a.valid, seq_valid[i]);
            check($sformatf("seq%0d_keys", i), bus_a.keys, seq_keys[i]);
            check($sformatf("seq%0d_changed", i), bus_a.changed, seq_chg[i]);
        end

        // WIDTH=8, DIV=2 instance
        rst_b_n = 1'b1;
        n = 0;
        wait_valid(1'b1, 200, n, ok);
        check("b_valid", ok, 1'b1);
        check("b_keys", bus_b.keys, 8'h80);
        check("b_key7", bus_b.keys[7], 1'b1);
        check("b_changed", bus_b.changed, 1'b1);
        n = 0;
        @(negedge sys_clk);
        n++;
        wait_valid(1'b1, 100, n, ok);
        check("b_valid2", ok, 1'b1);
        check("b_frame_period", n, 38);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
